muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS execute stage.
- Owns the HI/LO registers and runs one 32-cycle shift-add (or shift-subtract) operation at a time.
- Drives mult_done to the hazard unit, which stalls D/F while an op is in flight.
- Stalls any MFHI/MFLO in decode until HI/LO are valid.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_e  in  1  MULT/DIV instruction valid in E this cycle
- op_e  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca_e  in  WIDTH  rs operand (multiplicand/dividend), already forwarded
- srcb_e  in  WIDTH  rt operand (multiplier/divisor), already forwarded
- flush_e  in  1  E-stage flush; a start in the same cycle is suppressed
- cancel  in  1  abort in-flight op (exception); HI/LO keep old values
- mfhilo_d  in  1  MFHI/MFLO present in decode
- busy  out  1  op in flight (RUN or FIX)
- mult_done  out  1  ~busy; to hazard unit
- hilo_stall_d  out  1  mfhilo_d & busy
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi=0, lo=0, busy=0, mult_done=1, counter=0, internal regs=0.
- FSM states: IDLE, RUN, FIX.
- IDLE->RUN when start_e & ~flush_e & ~cancel and the op is supported.
  - Latch |srca|, |srcb| for signed ops, raw values for unsigned.
  - Latch neg_q = sign(a)^sign(b); latch neg_r = sign(a) (used for DIV only).
  - counter=WIDTH.
- RUN, multiply: each cycle, if acc-lsb of multiplier set, add multiplicand into upper half; shift the {upper,lower} product right 1.
- RUN, divide: each cycle, restoring step: shift the {rem,quot} pair left 1; trial subtract divisor; on non-negative result set the quotient bit and keep the difference.
- RUN: counter decrements by 1 per cycle; counter reaching 1 -> FIX.
- FIX (1 cycle):
  - Multiply: apply two's-complement negation of the 2*WIDTH product if neg_q; write hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient (negated if neg_q), hi=remainder (negated if neg_r).
  - Then -> IDLE.
- Latency: start in cycle T; hi/lo updated at the edge ending cycle T+WIDTH+1; mult_done=1 from cycle T+WIDTH+2. busy is registered and rises in T+1.
- start_e while busy: ignored; the hazard unit guarantees no issue while mult_done=0.
- cancel:
  - In RUN/FIX -> IDLE next edge, hi/lo unchanged.
  - cancel has priority over FIX write and over start.
- flush_e only gates start; it does not abort an in-flight op.
- Divide by zero: no trap; lo=all ones, hi=dividend (signed: original srca), after the full latency.
- Signed most-negative operands: magnitude taken in WIDTH+1 bits internally; e.g. MULT 0x80000000*0x80000000 gives hi=0x40000000, lo=0.
- Asynchronous reset mid-op: immediate return to IDLE with the reset values above.

Optional Feature:
- MULDIV_DIV_EN defined: DIV/DIVU supported as above.
- Not defined:
  - Divide datapath, neg_r and divide-by-zero logic are absent.
  - op_e[1]=1 starts are ignored; FSM stays IDLE, hi/lo unchanged, busy stays 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU (2 bits)
  - the state typedef md_state_t {IDLE, RUN, FIX}
  - the WIDTH default constant
- One natural sub-module, muldiv_step: the combinational single-iteration add/shift or subtract/shift, selected by a mode bit; it keeps the FSM file control-only.

Test Plan:
- MULTU 0xFFFFFFFF*0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; busy=1 for exactly 33 cycles; mult_done back high at T+34.
- MULT -3*5 (0xFFFFFFFD, 0x5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV 7/-2 (MULDIV_DIV_EN) -> lo=0xFFFFFFFD, hi=0x00000001; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- Preload hi=0x11, lo=0x22 via a MULTU; start MULTU 5*5; assert cancel at RUN cycle 10 -> IDLE next edge, hi=0x11, lo=0x22, mult_done=1.
- mfhilo_d=1 during RUN -> hilo_stall_d=1 every busy cycle, 0 in the cycle mult_done returns high; start_e=1 with flush_e=1 -> no start, busy stays 0.
- Drop rst_n mid-RUN (cycle 15) -> hi=lo=0, busy=0 asynchronously; a fresh MULTU 3*4 after release -> lo=12, hi=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared execute-stage definitions: multiply/divide op encodings, sequencer
// state type and the default datapath width.
package pipeline_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: shift-add for multiply, and
// (when MULDIV_DIV_EN is defined) restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
`endif

  always_comb begin
    // Multiply: carry out of the add becomes the new top bit after the shift.
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd};
    if (div_mode) begin
      nxt_hi = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO (WIDTH iterations per op).
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise divide starts are ignored.
module muldiv_seq
  import pipeline_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             flush_e,
  input  logic             cancel,
  input  logic             mfhilo_d,
  output logic             busy,
  output logic             mult_done,
  output logic             hilo_stall_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_q, signed_op, supported, start_ok;
  logic             do_load, do_write;
`ifdef MULDIV_DIV_EN
  logic             op_div, is_div, neg_r, div_zero;
`endif

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  // The most negative value's magnitude is exact when read back as unsigned.
  assign a_mag = cneg(srca_e, signed_op & srca_e[WIDTH-1]);
  assign b_mag = cneg(srcb_e, signed_op & srcb_e[WIDTH-1]);

`ifdef MULDIV_DIV_EN
  assign op_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign supported = 1'b1;
`else
  assign supported = ~op_e[1];
`endif

  assign start_ok     = start_e & ~flush_e & ~cancel & supported;
  assign busy         = (state != IDLE);
  assign mult_done    = ~busy;
  assign hilo_stall_d = mfhilo_d & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_write = 1'b0;
    case (state)
      IDLE: if (start_ok) begin
        state_nx = RUN;
        do_load  = 1'b1;
      end
      RUN: begin
        if (cancel)                  state_nx = IDLE;
        else if (cnt == CNT_W'(1))   state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
        do_write = ~cancel;
      end
      default: state_nx = IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .opnd     (opnd),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      if (do_load) begin
        cnt    <= CNT_W'(WIDTH);
        acc_hi <= '0;
        neg_q  <= signed_op & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        is_div   <= op_div;
        neg_r    <= signed_op & srca_e[WIDTH-1];
        div_zero <= (srcb_e == '0);
        acc_lo   <= op_div ? a_mag : b_mag;
        opnd     <= op_div ? b_mag : a_mag;
`else
        acc_lo <= b_mag;
        opnd   <= a_mag;
`endif
      end else if (state == RUN) begin
        cnt    <= cnt - 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end
      // Sign fix-up and HI/LO commit happen only in FIX, and never on cancel.
      if (do_write) begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          lo <= div_zero ? '1 : cneg(acc_lo, neg_q);
          hi <= cneg(acc_hi, neg_r);
        end else begin
          {hi, lo} <= cneg2({acc_hi, acc_lo}, neg_q);
        end
`else
        {hi, lo} <= cneg2({acc_hi, acc_lo}, neg_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic HI/LO model.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_e, flush_e, cancel, mfhilo_d;
  logic [1:0]   op_e;
  logic [W-1:0] srca_e, srcb_e;
  logic         busy, mult_done, hilo_stall_d;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_e      (start_e),
    .op_e         (op_e),
    .srca_e       (srca_e),
    .srcb_e       (srcb_e),
    .flush_e      (flush_e),
    .cancel       (cancel),
    .mfhilo_d     (mfhilo_d),
    .busy         (busy),
    .mult_done    (mult_done),
    .hilo_stall_d (hilo_stall_d),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected HI/LO from plain arithmetic; sup=0 means the op must not start.
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eh, output logic [W-1:0] el, output bit sup);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sup = 1'b1;
    eh  = model_hi;
    el  = model_lo;
    case (op)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 0) begin
          el = '1;
          eh = a;
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
`else
        sup = 1'b0;
`endif
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_val();
    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, follow it to completion and check timing and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic mf);
    logic [W-1:0] eh, el;
    bit sup;
    int n, stall_bad;
    ref_op(op, a, b, eh, el, sup);
    start_e = 1'b1; op_e = op; srca_e = a; srcb_e = b; mfhilo_d = mf;
    tick();
    start_e = 1'b0; srca_e = $urandom; srcb_e = $urandom;
    if (!sup) begin
      check({tag, "_nostart_busy"}, busy, 1'b0);
      check({tag, "_nostart_hi"}, hi, model_hi);
      check({tag, "_nostart_lo"}, lo, model_lo);
      mfhilo_d = 1'b0;
      return;
    end
    n = 0;
    stall_bad = 0;
    while (busy && n < 100) begin
      n++;
      if (hilo_stall_d !== mf) stall_bad++;
      if (n == W + 1) check({tag, "_hi_before_commit"}, hi, model_hi);
      // A second start while busy must be ignored.
      start_e = (n == 5);
      op_e = 2'($urandom);
      tick();
    end
    start_e = 1'b0;
    check({tag, "_busy_cycles"}, n, W + 1);
    check({tag, "_mult_done"}, mult_done, 1'b1);
    check({tag, "_stall_busy"}, stall_bad, 0);
    check({tag, "_stall_done"}, hilo_stall_d, 1'b0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    model_hi = eh;
    model_lo = el;
    mfhilo_d = 1'b0;
  endtask

  task automatic start_only(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_e = 1'b1; op_e = op; srca_e = a; srcb_e = b;
    tick();
    start_e = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_e = 1'b0; flush_e = 1'b0; cancel = 1'b0; mfhilo_d = 1'b0;
    op_e = 2'b00; srca_e = '0; srcb_e = '0;
    repeat (3) @(posedge clk);
    #1;
    mfhilo_d = 1'b1;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_mult_done", mult_done, 1'b1);
    check("rst_stall", hilo_stall_d, 1'b0);
    mfhilo_d = 1'b0;
    rst_n = 1'b1;
    tick();

    run_op("multu_ff_x2", 2'b01, 32'hFFFF_FFFF, 32'h2, 1'b1);
    check("multu_ff_x2_hi_const", hi, 32'h1);
    check("multu_ff_x2_lo_const", lo, 32'hFFFF_FFFE);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'h5, 1'b0);
    check("mult_m3x5_lo_const", lo, 32'hFFFF_FFF1);
    run_op("mult_minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mult_minneg_hi_const", hi, 32'h4000_0000);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("divu_100_0", 2'b11, 32'd100, 32'd0, 1'b0);
    run_op("div_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0, 1'b0);

    // Preload hi=0x11, lo=0x22, then cancel a MULTU at RUN cycle 10.
    run_op("preload", 2'b01, 32'h66, 32'h2AAA_AAAB, 1'b0);
    check("preload_hi_const", hi, 32'h11);
    start_only(2'b01, 32'd5, 32'd5);
    repeat (9) tick();
    check("cancel_run_busy_before", busy, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_run_busy", busy, 1'b0);
    check("cancel_run_done", mult_done, 1'b1);
    check("cancel_run_hi", hi, 32'h11);
    check("cancel_run_lo", lo, 32'h22);
    repeat (40) tick();
    check("cancel_run_hi_later", hi, 32'h11);
    check("cancel_run_lo_later", lo, 32'h22);

    // Cancel landing on the FIX cycle suppresses the write.
    start_only(2'b01, 32'd7, 32'd9);
    repeat (W) tick();
    check("cancel_fix_busy_before", busy, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_fix_busy", busy, 1'b0);
    check("cancel_fix_hi", hi, 32'h11);
    check("cancel_fix_lo", lo, 32'h22);

    // Start gated by flush, and by a simultaneous cancel.
    flush_e = 1'b1;
    start_only(2'b01, 32'd3, 32'd3);
    flush_e = 1'b0;
    check("flush_busy", busy, 1'b0);
    tick();
    check("flush_busy_later", busy, 1'b0);
    cancel = 1'b1;
    start_only(2'b00, 32'd3, 32'd3);
    cancel = 1'b0;
    check("cancel_start_busy", busy, 1'b0);
    check("flush_hi", hi, 32'h11);

    // Asynchronous reset at RUN cycle 15.
    start_only(2'b01, 32'd1234, 32'd5678);
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", mult_done, 1'b1);
    tick();
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    tick();
    check("arst_busy_after", busy, 1'b0);
    run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0);
    check("multu_3x4_lo_const", lo, 32'd12);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom);
      a = pick_val();
      b = pick_val();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
